// File: rtl/jk_pkg.sv
// Shared definitions for the JK register bank: mode codes and the JK action encoding.
package jk_pkg;

    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_UP = 2'b01;
    localparam logic [1:0] MODE_DN = 2'b10;
    localparam logic [1:0] MODE_SH = 2'b11;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_CLR    = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_act_e;

    function automatic jk_act_e jk_decode(input logic j, input logic k);
        return jk_act_e'({j, k});
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-high reset to a per-cell reset value.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        unique case (jk_decode(j, k))
            JK_HOLD:   q_d = q_q;
            JK_CLR:    q_d = 1'b0;
            JK_SET:    q_d = 1'b1;
            JK_TOGGLE: q_d = ~q_q;
            default:   q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= rst_val;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK cells steered as a free JK register, up/down counter or left shifter.
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             ser_out
);

    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] qbar_w;
    logic [WIDTH-1:0] j_eff;
    logic [WIDTH-1:0] k_eff;
    logic [WIDTH-1:0] shl;
    logic             carry_up;
    logic             carry_dn;

    assign shl = {q_w[WIDTH-2:0], ser_in};

    // Carry terms accumulate low-to-high so every bit sees the AND of all bits below it.
    always_comb begin
        j_eff    = '0;
        k_eff    = '0;
        carry_up = 1'b1;
        carry_dn = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            unique case (mode)
                MODE_JK: begin
                    j_eff[i] = j[i];
                    k_eff[i] = k[i];
                end
                MODE_UP: begin
                    j_eff[i] = carry_up;
                    k_eff[i] = carry_up;
                end
                MODE_DN: begin
                    j_eff[i] = carry_dn;
                    k_eff[i] = carry_dn;
                end
                MODE_SH: begin
                    j_eff[i] = shl[i];
                    k_eff[i] = ~shl[i];
                end
                default: begin
                    j_eff[i] = 1'b0;
                    k_eff[i] = 1'b0;
                end
            endcase
            carry_up = carry_up & q_w[i];
            carry_dn = carry_dn & ~q_w[i];
        end
        if (!en) begin
            j_eff = '0;
            k_eff = '0;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .rst_val (RESET_VAL[g]),
            .j       (j_eff[g]),
            .k       (k_eff[g]),
            .q       (q_w[g]),
            .qbar    (qbar_w[g])
        );
    end

    assign q       = q_w;
    assign qbar    = qbar_w;
    assign ser_out = q_w[WIDTH-1];
    assign tc      = ((mode == MODE_UP) && (&q_w)) ||
                     ((mode == MODE_DN) && (~|q_w));

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed, table-driven bench for jk_reg_bank (WIDTH=4, RESET_VAL=0).
module tb_jk_reg_bank;
    import jk_pkg::*;

    logic       clk;
    logic       clk_run;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] j;
    logic [3:0] k;
    logic       ser_in;
    logic [3:0] q;
    logic [3:0] qbar;
    logic       tc;
    logic       ser_out;

    int passed;
    int total;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [3:0] j;
        logic [3:0] k;
        logic       ser_in;
        logic [3:0] exp_q;
        logic       exp_tc;
        logic       exp_ser;
    } vec_t;

    vec_t vecs[$];

    jk_reg_bank #(
        .WIDTH     (4),
        .RESET_VAL (4'b0000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .j       (j),
        .k       (k),
        .ser_in  (ser_in),
        .q       (q),
        .qbar    (qbar),
        .tc      (tc),
        .ser_out (ser_out)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] eq,
                             input logic etc, input logic eser);
        check({tag, " q"}, q, eq);
        check({tag, " qbar"}, qbar, ~eq);
        check({tag, " tc"}, {3'b000, tc}, {3'b000, etc});
        check({tag, " ser_out"}, {3'b000, ser_out}, {3'b000, eser});
    endtask

    function automatic void add(input logic e, input logic [1:0] m, input logic [3:0] jj,
                                input logic [3:0] kk, input logic s, input logic [3:0] eq,
                                input logic etc);
        vec_t v;
        v.en = e; v.mode = m; v.j = jj; v.k = kk; v.ser_in = s;
        v.exp_q = eq; v.exp_tc = etc; v.exp_ser = eq[3];
        vecs.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        clk_run = 1'b0;
        en      = 1'b1;
        mode    = MODE_DN;
        j       = 4'b0000;
        k       = 4'b0000;
        ser_in  = 1'b0;
        rst     = 1'b0;

        // Reset with the clock stopped
        #2 rst = 1'b1;
        #1;
        check_all("reset mode10", 4'b0000, 1'b1, 1'b0);
        mode = MODE_JK;
        #1;
        check("reset mode00 tc", {3'b000, tc}, 4'b0000);
        #1 rst = 1'b0;
        clk_run = 1'b1;

        // JK mode: set/toggle/clear mix, then second edge toggles bit 1 back
        add(1, MODE_JK, 4'b1010, 4'b0110, 0, 4'b1010, 0);
        add(1, MODE_JK, 4'b1010, 4'b0110, 0, 4'b1000, 0);
        add(1, MODE_JK, 4'b0000, 4'b1111, 0, 4'b0000, 0);
        // Up count over a full wrap, with junk on j/k/ser_in that must be ignored
        for (int i = 1; i <= 16; i++) begin
            add(1, MODE_UP, 4'b1111, 4'b0101, 1, 4'(i % 16), (i % 16) == 15);
        end
        // Down count from zero wraps to all ones
        add(1, MODE_DN, 4'b0011, 4'b1100, 1, 4'b1111, 0);
        add(1, MODE_DN, 4'b0000, 4'b0000, 0, 4'b1110, 0);
        add(1, MODE_DN, 4'b0000, 4'b0000, 0, 4'b1101, 0);
        add(1, MODE_DN, 4'b0000, 4'b0000, 0, 4'b1100, 0);
        add(0, MODE_DN, 4'b0000, 4'b0000, 0, 4'b1100, 0);
        // Shift from zero
        add(1, MODE_JK, 4'b0000, 4'b1111, 0, 4'b0000, 0);
        add(1, MODE_SH, 4'b1111, 4'b1111, 1, 4'b0001, 0);
        add(1, MODE_SH, 4'b1111, 4'b1111, 0, 4'b0010, 0);
        add(1, MODE_SH, 4'b0000, 4'b0000, 1, 4'b0101, 0);
        add(1, MODE_SH, 4'b0000, 4'b0000, 1, 4'b1011, 0);
        add(0, MODE_SH, 4'b0000, 4'b0000, 0, 4'b1011, 0);
        // Load 0101 then hold in up mode with en low
        add(1, MODE_JK, 4'b0101, 4'b1010, 0, 4'b0101, 0);
        add(0, MODE_UP, 4'b1111, 4'b1111, 1, 4'b0101, 0);
        add(0, MODE_UP, 4'b1111, 4'b1111, 1, 4'b0101, 0);
        add(0, MODE_UP, 4'b1111, 4'b1111, 1, 4'b0101, 0);

        @(negedge clk);
        for (int v = 0; v < vecs.size(); v++) begin
            en     = vecs[v].en;
            mode   = vecs[v].mode;
            j      = vecs[v].j;
            k      = vecs[v].k;
            ser_in = vecs[v].ser_in;
            step();
            check_all($sformatf("vec%0d", v), vecs[v].exp_q, vecs[v].exp_tc, vecs[v].exp_ser);
        end

        // Async reset pulse between edges while counting
        en = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_all("midreset", 4'b0000, 1'b0, 1'b0);
        #1 rst = 1'b0;
        step();
        check_all("post-reset edge", 4'b0001, 1'b0, 1'b0);
        step();
        check("post-reset edge2 q", q, 4'b0010);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish, expected finish before 20000");
        $fatal(1);
    end

endmodule
